// File: rtl/bsg_fsb_pkg.sv
// Shared constants and types for the front-side-bus hop blocks.
package bsg_fsb_pkg;

    localparam int fsb_width_gp     = 16;
    localparam int fsb_els_gp       = 2;
    localparam int fsb_cnt_width_gp = 16;

    typedef logic [$clog2(fsb_els_gp)-1:0] fsb_src_id_t;
    typedef logic [fsb_cnt_width_gp-1:0]   fsb_cnt_t;

endpackage

// File: rtl/bsg_fsb_rr_arb.sv
// Round-robin arbiter over per-source FIFO heads; the grant is frozen
// while the downstream stalls so the presented flit stays stable until taken.
module bsg_fsb_rr_arb
    import bsg_fsb_pkg::*;
#(
    parameter  int els_p     = fsb_els_gp,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [els_p-1:0]     req_i,
    input  logic                 ready_i,
    output logic                 v_o,
    output logic [lg_els_lp-1:0] gnt_id_o,
    output logic [els_p-1:0]     yumi_o
);

    logic [lg_els_lp-1:0] rr_r;
    logic [lg_els_lp-1:0] hold_id_r;
    logic                 hold_v_r;
    logic [lg_els_lp-1:0] rr_gnt;
    logic [lg_els_lp-1:0] cand;
    logic                 xfer;

    // Scan from the farthest candidate back to rr_r so the nearest requester wins.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        rr_gnt = '0;
        cand   = '0;
        for (int k = els_p - 1; k >= 0; k--) begin
            cand = lg_els_lp'((int'(rr_r) + k) % els_p);
            if (req_i[cand]) begin
                rr_gnt = cand;
            end
        end
    end

    assign v_o      = |req_i;
    assign gnt_id_o = hold_v_r ? hold_id_r : rr_gnt;
    assign xfer     = v_o & ready_i;
    assign yumi_o   = xfer ? (els_p'(1) << gnt_id_o) : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_r      <= '0;
            hold_v_r  <= 1'b0;
            hold_id_r <= '0;
        end else begin
            if (xfer) begin
                rr_r <= (gnt_id_o == lg_els_lp'(els_p - 1)) ? '0 : gnt_id_o + lg_els_lp'(1);
            end
            hold_v_r  <= v_o & ~ready_i;
            hold_id_r <= gnt_id_o;
        end
    end

endmodule

// File: rtl/bsg_front_side_bus_hop_out.sv
// Front-side-bus hop merge stage: per-source 2-entry FIFOs feeding a round-robin merge.
// Define BSG_FSB_HOP_OUT_STATS_EN to add per-source transfer counters on sent_cnt_o.
module bsg_front_side_bus_hop_out
    import bsg_fsb_pkg::*;
#(
    parameter  int width_p   = fsb_width_gp,
    parameter  int els_p     = fsb_els_gp,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [els_p-1:0]            v_i,
    input  logic [els_p*width_p-1:0]    data_i,
    output logic [els_p-1:0]            ready_o,
    output logic                        v_o,
    output logic [width_p-1:0]          data_o,
    output logic [lg_els_lp-1:0]        src_id_o,
`ifdef BSG_FSB_HOP_OUT_STATS_EN
    output logic [els_p*fsb_cnt_width_gp-1:0] sent_cnt_o,
`endif
    input  logic                        ready_i
);

    logic [els_p-1:0]     fifo_v;
    logic [els_p-1:0]     yumi;
    logic [width_p-1:0]   fifo_head [els_p];
    logic [lg_els_lp-1:0] gnt;

    for (genvar i = 0; i < els_p; i++) begin : g_fifo
        logic [width_p-1:0] mem_r [2];
        logic               wr_ptr_r;
        logic               rd_ptr_r;
        logic [1:0]         count_r;
        logic               enq;

        // Ready depends only on occupancy, so enqueue and dequeue never meet on a full FIFO.
        assign ready_o[i]   = (count_r != 2'd2);
        assign fifo_v[i]    = (count_r != 2'd0);
        assign enq          = v_i[i] & ready_o[i];
        assign fifo_head[i] = mem_r[rd_ptr_r];

        // NOTE: storage is left unreset; occupancy is reset and the output mux masks empty heads.
        always_ff @(posedge clk_i) begin
            if (enq) begin
                mem_r[wr_ptr_r] <= data_i[i*width_p +: width_p];
            end
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                wr_ptr_r <= 1'b0;
                rd_ptr_r <= 1'b0;
                count_r  <= 2'd0;
            end else begin
                if (enq)     wr_ptr_r <= ~wr_ptr_r;
                if (yumi[i]) rd_ptr_r <= ~rd_ptr_r;
                case ({enq, yumi[i]})
                    2'b10:   count_r <= count_r + 2'd1;
                    2'b01:   count_r <= count_r - 2'd1;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    bsg_fsb_rr_arb #(
        .els_p (els_p)
    ) arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .req_i     (fifo_v),
        .ready_i   (ready_i),
        .v_o       (v_o),
        .gnt_id_o  (gnt),
        .yumi_o    (yumi)
    );

    assign data_o   = v_o ? fifo_head[gnt] : '0;
    assign src_id_o = gnt;

`ifdef BSG_FSB_HOP_OUT_STATS_EN
    for (genvar i = 0; i < els_p; i++) begin : g_stats
        fsb_cnt_t cnt_r;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cnt_r <= '0;
            end else if (yumi[i]) begin
                cnt_r <= cnt_r + fsb_cnt_t'(1);
            end
        end

        assign sent_cnt_o[i*fsb_cnt_width_gp +: fsb_cnt_width_gp] = cnt_r;
    end
`endif

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out.sv
// Randomized and directed bench for bsg_front_side_bus_hop_out against a queue-based reference model.
module tb_bsg_front_side_bus_hop_out;

    localparam int W   = 16;
    localparam int ELS = 2;

    logic               clk_i = 1'b0;
    logic               reset_n_i;
    logic [ELS-1:0]     v_i;
    logic [ELS*W-1:0]   data_i;
    logic [ELS-1:0]     ready_o;
    logic               v_o;
    logic [W-1:0]       data_o;
    logic [0:0]         src_id_o;
    logic               ready_i;
`ifdef BSG_FSB_HOP_OUT_STATS_EN
    logic [ELS*16-1:0]  sent_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    bsg_front_side_bus_hop_out #(
        .width_p (W),
        .els_p   (ELS)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .src_id_o  (src_id_o),
`ifdef BSG_FSB_HOP_OUT_STATS_EN
        .sent_cnt_o(sent_cnt_o),
`endif
        .ready_i   (ready_i)
    );

    // Reference model: queued flits per source, next-priority source, pending stall.
    logic [W-1:0] q [ELS][$];
    int           m_rr;
    bit           m_hold_v;
    int           m_hold_id;
    int           sent [ELS];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        for (int i = 0; i < ELS; i++) if (q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_gnt();
        if (m_hold_v) return m_hold_id;
        for (int k = 0; k < ELS; k++) begin
            int idx;
            idx = (m_rr + k) % ELS;
            if (q[idx].size() > 0) return idx;
        end
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ELS; i++) begin
            q[i].delete();
            sent[i] = 0;
        end
        m_rr      = 0;
        m_hold_v  = 1'b0;
        m_hold_id = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit           mv;
        int           g;
        bit [ELS-1:0] acc;
        mv = m_valid();
        g  = m_gnt();
        for (int i = 0; i < ELS; i++) acc[i] = v_i[i] && (q[i].size() < 2);
        if (mv && ready_i) begin
            q[g].delete(0);
            sent[g]++;
            m_rr = (g + 1) % ELS;
        end
        for (int i = 0; i < ELS; i++) if (acc[i]) q[i].push_back(data_i[i*W +: W]);
        m_hold_v  = mv && !ready_i;
        m_hold_id = g;
    endtask

    task automatic compare(input string tag);
        for (int i = 0; i < ELS; i++) check({tag, "_ready"}, 32'(ready_o[i]), 32'(q[i].size() < 2));
        check({tag, "_v"}, 32'(v_o), 32'(m_valid()));
        if (m_valid()) begin
            check({tag, "_src"}, 32'(src_id_o), m_gnt());
            check({tag, "_data"}, 32'(data_o), 32'(q[m_gnt()][0]));
        end else begin
            check({tag, "_data_idle"}, 32'(data_o), 32'd0);
        end
`ifdef BSG_FSB_HOP_OUT_STATS_EN
        for (int i = 0; i < ELS; i++)
            check({tag, "_cnt"}, 32'(sent_cnt_o[i*16 +: 16]), sent[i] & 32'hFFFF);
`endif
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk_i);
        #1;
        compare(tag);
    endtask

    task automatic drive(input logic [ELS-1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic rdy);
        v_i     = v;
        data_i  = {d1, d0};
        ready_i = rdy;
    endtask

    task automatic drain();
        drive(2'b00, '0, '0, 1'b1);
        for (int n = 0; n < 5; n++) cycle("drain");
    endtask

    // Reset is asserted between edges; outputs must return to idle before any clock.
    task automatic do_reset(input string tag);
        reset_n_i = 1'b0;
        drive(2'b00, '0, '0, 1'b0);
        #1;
        check({tag, "_rst_v"}, 32'(v_o), 32'd0);
        check({tag, "_rst_ready"}, 32'(ready_o), 32'b11);
        check({tag, "_rst_data"}, 32'(data_o), 32'd0);
        check({tag, "_rst_src"}, 32'(src_id_o), 32'd0);
        model_clear();
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        compare(tag);
    endtask

    initial begin
        int c0;
        int c1;
        bit a0;
        bit a1;

        reset_n_i = 1'b0;
        drive(2'b00, '0, '0, 1'b0);
        model_clear();
        @(posedge clk_i);
        #1;
        do_reset("init");

        // Random traffic with random downstream stalls.
        for (int n = 0; n < 400; n++) begin
            v_i     = ELS'($urandom);
            data_i  = ($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        // Reset mid-traffic: make sure flits are queued first.
        drive(2'b11, 16'h7777, 16'h8888, 1'b0);
        cycle("pre_rst");
        do_reset("mid");
        drive(2'b10, '0, 16'hA5A5, 1'b1);
        cycle("t1");
        check("t1_v", 32'(v_o), 32'd1);
        check("t1_src", 32'(src_id_o), 32'd1);
        check("t1_data", 32'(data_o), 32'hA5A5);
        drain();

        // Both sources always offering: grants alternate, per-source order kept.
        c0 = 0;
        c1 = 0;
        for (int n = 0; n < 20; n++) begin
            drive(2'b11, W'(16'h0000 + c0), W'(16'h1000 + c1), 1'b1);
            a0 = q[0].size() < 2;
            a1 = q[1].size() < 2;
            cycle("rr");
            if (a0) c0++;
            if (a1) c1++;
            check("rr_alt", 32'(src_id_o), n % 2);
            check("rr_order", 32'(data_o), (n % 2 == 0) ? (n / 2) : (32'h1000 + n / 2));
        end
        drain();

        // Stall: src1 head stays presented while src0 arrives later.
        drive(2'b10, '0, 16'hBEEF, 1'b0);
        cycle("hold_in");
        for (int n = 1; n <= 5; n++) begin
            if (n == 2) drive(2'b01, 16'h0C0C, '0, 1'b0);
            else        drive(2'b00, '0, '0, 1'b0);
            cycle("hold");
            check("hold_data", 32'(data_o), 32'hBEEF);
            check("hold_src", 32'(src_id_o), 32'd1);
        end
        drive(2'b00, '0, '0, 1'b1);
        cycle("hold_out");
        check("hold_next_src", 32'(src_id_o), 32'd0);
        check("hold_next_data", 32'(data_o), 32'h0C0C);
        drain();

        // Backpressure on src0: two accepted, third waits for a transfer.
        drive(2'b01, 16'h4000, '0, 1'b0);
        cycle("bp1");
        drive(2'b01, 16'h4001, '0, 1'b0);
        cycle("bp2");
        check("bp_full", 32'(ready_o[0]), 32'd0);
        drive(2'b01, 16'h4002, '0, 1'b0);
        cycle("bp3");
        check("bp_still_full", 32'(ready_o[0]), 32'd0);
        drive(2'b01, 16'h4002, '0, 1'b1);
        cycle("bp4");
        check("bp_reopen", 32'(ready_o[0]), 32'd1);
        check("bp_head", 32'(data_o), 32'h4001);
        drive(2'b01, 16'h4002, '0, 1'b0);
        cycle("bp5");
        check("bp_refull", 32'(ready_o[0]), 32'd0);
        drain();

        // Single-source stream on src1: one transfer per cycle.
        for (int n = 1; n <= 10; n++) begin
            drive(2'b10, '0, W'(16'h5000 + n - 1), 1'b1);
            cycle("ss");
            check("ss_v", 32'(v_o), 32'd1);
            check("ss_src", 32'(src_id_o), 32'd1);
            check("ss_data", 32'(data_o), 32'h5000 + n - 1);
        end
        drive(2'b00, '0, '0, 1'b1);
        cycle("ss_last");
        drive(2'b11, 16'h5A00, 16'h5B00, 1'b0);
        cycle("ss_rr");
        check("ss_rr_zero", 32'(src_id_o), 32'd0);
        drain();

`ifdef BSG_FSB_HOP_OUT_STATS_EN
        do_reset("st");
        for (int n = 0; n < 10; n++) begin
            drive(2'b01, W'(n), '0, 1'b1);
            cycle("st0");
        end
        drain();
        for (int n = 0; n < 7; n++) begin
            drive(2'b10, '0, W'(n), 1'b1);
            cycle("st1");
        end
        drain();
        check("st_counts", 32'(sent_cnt_o), {16'd7, 16'd10});
        do_reset("wrap");
        for (int n = 0; n < 65536; n++) begin
            drive(2'b01, W'(n), '0, 1'b1);
            cycle("wr");
        end
        drain();
        check("st_wrap", 32'(sent_cnt_o), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
